// File: rtl/sdf_stage_ctrl.sv
// Control FSM for one radix-2 single-path delay-feedback FFT stage: sequences the
// delay line, butterfly select and W32 twiddle index across fill, run and flush.
module sdf_stage_ctrl #(
    parameter int LOG2_DELAY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       sr_en,
    output logic       bfly_sel,
    output logic [3:0] tw_addr,
    output logic       out_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    localparam int DELAY = 1 << LOG2_DELAY;
    localparam int KW    = LOG2_DELAY + 1;

    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [KW-1:0] K_HALF  = KW'(DELAY);
    localparam logic [KW-1:0] K_DM1   = KW'(DELAY - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(2 * DELAY - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k, k_nxt;
    logic          err_nxt;
    logic          accept;
    logic [7:0]    tw_wide;

    // Reset is folded in so that no shift or output strobe escapes while it is held.
    assign in_ready = (state != FLUSH);
    assign accept   = in_valid && in_ready && !reset;
    assign busy     = (state != IDLE);
    assign tw_wide  = 8'(k) << (4 - LOG2_DELAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        err_nxt    = err;
        sr_en      = 1'b0;
        bfly_sel   = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        tw_addr    = '0;

        case (state)
            IDLE: begin
                sr_en = accept;
                if (accept) begin
                    if (in_last) begin
                        state_nxt = FLUSH;
                        k_nxt     = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        k_nxt     = K_ONE;
                        state_nxt = (DELAY == 1) ? RUN : FILL;
                    end
                end
            end
            FILL: begin
                sr_en = accept;
                if (accept) begin
                    if (in_last) begin
                        state_nxt = FLUSH;
                        k_nxt     = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        k_nxt = k + K_ONE;
                        if (k == K_DM1) state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                sr_en     = accept;
                out_valid = accept;
                bfly_sel  = (k >= K_HALF);
                if (accept) begin
                    if (in_last) begin
                        state_nxt = FLUSH;
                        k_nxt     = '0;
                        if (k != K_LAST) err_nxt = 1'b1;
                    end else begin
                        // Natural wrap at 2*DELAY keeps back-to-back blocks gapless.
                        k_nxt = k + K_ONE;
                    end
                end
            end
            FLUSH: begin
                sr_en     = 1'b1;
                out_valid = 1'b1;
                if (k == K_DM1) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                    k_nxt      = '0;
                end else begin
                    k_nxt = k + K_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Twiddles apply only to the difference path leaving the delay line.
        if (out_valid && !bfly_sel) tw_addr = tw_wide[3:0];
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl: a DELAY=16 instance for most scenarios and a
// DELAY=4 instance for the short-frame case.
module tb_sdf_stage_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_last;
    logic       in_ready, sr_en, bfly_sel, out_valid, busy, frame_done, err;
    logic [3:0] tw_addr;
    logic       in_valid_b, in_last_b;
    logic       in_ready_b, sr_en_b, bfly_sel_b, out_valid_b, busy_b, frame_done_b, err_b;
    logic [3:0] tw_addr_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.LOG2_DELAY(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .sr_en(sr_en), .bfly_sel(bfly_sel), .tw_addr(tw_addr),
        .out_valid(out_valid), .busy(busy), .frame_done(frame_done), .err(err)
    );

    sdf_stage_ctrl #(.LOG2_DELAY(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_last(in_last_b),
        .in_ready(in_ready_b), .sr_en(sr_en_b), .bfly_sel(bfly_sel_b), .tw_addr(tw_addr_b),
        .out_valid(out_valid_b), .busy(busy_b), .frame_done(frame_done_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic l);
        in_valid = v;
        in_last  = l;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts with frame-relative indices first..first+n-1; DELAY=16, so k = a mod 32.
    task automatic run_accepts(input int n, input bit last_at_end, input int first);
        int  kk;
        bit  run;
        for (int a = first; a < first + n; a++) begin
            step(1'b1, last_at_end && (a == first + n - 1));
            kk  = a % 32;
            run = (a >= 16);
            chk("acc_in_ready", in_ready, 1);
            chk("acc_sr_en", sr_en, 1);
            chk("acc_out_valid", out_valid, run);
            chk("acc_bfly_sel", bfly_sel, run && (kk >= 16));
            chk("acc_tw_addr", tw_addr, (run && kk < 16) ? kk : 0);
            chk("acc_busy", busy, a != 0);
            chk("acc_frame_done", frame_done, 0);
            tick();
        end
    endtask

    // Sixteen flush cycles with junk on in_valid/in_last, then the idle cycle after.
    task automatic run_flush(input logic exp_err);
        for (int i = 0; i < 16; i++) begin
            step(i[0], i == 3);
            chk("fl_in_ready", in_ready, 0);
            chk("fl_sr_en", sr_en, 1);
            chk("fl_out_valid", out_valid, 1);
            chk("fl_bfly_sel", bfly_sel, 0);
            chk("fl_tw_addr", tw_addr, i);
            chk("fl_frame_done", frame_done, i == 15);
            chk("fl_busy", busy, 1);
            tick();
        end
        step(1'b0, 1'b0);
        chk("post_busy", busy, 0);
        chk("post_frame_done", frame_done, 0);
        chk("post_out_valid", out_valid, 0);
        chk("post_err", err, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_last    = 1'b1;
        in_valid_b = 1'b0;
        in_last_b  = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sr_en", sr_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bfly_sel", bfly_sel, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        tick();
        reset = 1'b0;

        // Scenario 1: single clean frame
        run_accepts(32, 1'b1, 0);
        run_flush(1'b0);

        // Scenario 2: three-cycle stall after the 20th accept
        run_accepts(20, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("stall_sr_en", sr_en, 0);
            chk("stall_out_valid", out_valid, 0);
            chk("stall_bfly_sel", bfly_sel, 1);
            chk("stall_tw_addr", tw_addr, 0);
            chk("stall_busy", busy, 1);
            tick();
        end
        run_accepts(12, 1'b1, 20);
        run_flush(1'b0);

        // Scenario 3: two back-to-back blocks in one frame
        run_accepts(64, 1'b1, 0);
        run_flush(1'b0);

        // Scenario 4: in_last on the 10th accept, then a clean frame
        run_accepts(10, 1'b1, 0);
        chk("ferr_err_set", err, 1);
        run_flush(1'b1);
        run_accepts(32, 1'b1, 0);
        run_flush(1'b1);

        // Scenario 5: DELAY=4 instance, 8-sample frame
        for (int a = 0; a < 8; a++) begin
            in_valid_b = 1'b1;
            in_last_b  = (a == 7);
            #1;
            chk("b_sr_en", sr_en_b, 1);
            chk("b_out_valid", out_valid_b, a >= 4);
            chk("b_bfly_sel", bfly_sel_b, a >= 4);
            chk("b_tw_addr", tw_addr_b, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            in_valid_b = 1'b1;
            in_last_b  = 1'b0;
            #1;
            chk("b_fl_in_ready", in_ready_b, 0);
            chk("b_fl_tw_addr", tw_addr_b, i * 4);
            chk("b_fl_frame_done", frame_done_b, i == 3);
            tick();
        end
        in_valid_b = 1'b0;
        #1;
        chk("b_post_busy", busy_b, 0);
        chk("b_post_err", err_b, 0);
        tick();

        // Scenario 6: reset in flush cycle 5, err from scenario 4 still set
        run_accepts(32, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk("rf_tw_addr", tw_addr, i);
            chk("rf_frame_done", frame_done, 0);
            tick();
        end
        step(1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("rf_rst_in_ready", in_ready, 1);
        chk("rf_rst_sr_en", sr_en, 0);
        chk("rf_rst_out_valid", out_valid, 0);
        chk("rf_rst_tw_addr", tw_addr, 0);
        chk("rf_rst_busy", busy, 0);
        chk("rf_rst_err", err, 0);
        chk("rf_rst_frame_done", frame_done, 0);
        tick();
        chk("rf_hold_frame_done", frame_done, 0);
        chk("rf_hold_busy", busy, 0);
        reset = 1'b0;
        run_accepts(32, 1'b1, 0);
        run_flush(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
